// File: rtl/sigmoid_pwl7_dual.sv
// Two-lane, 3-stage pipelined sigmoid: 7-slice piecewise-linear fit, shift-add only.
// Each lane takes |x|, evaluates a 4-segment PWL on it, then mirrors for negative inputs.
module sigmoid_pwl7_dual #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] x0_in,
    input  logic [DATA_W-1:0] x1_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] y0_out,
    output logic [DATA_W-1:0] y1_out,
    output logic              valid_out
);

    localparam logic [DATA_W-1:0] ONE     = DATA_W'(1 << FRAC_W);
    localparam logic [DATA_W-1:0] BP_MID  = DATA_W'(19 << (FRAC_W - 3));
    localparam logic [DATA_W-1:0] BP_HIGH = DATA_W'(5 << FRAC_W);
    localparam logic [DATA_W-1:0] OFS_LO  = DATA_W'(1 << (FRAC_W - 1));
    localparam logic [DATA_W-1:0] OFS_MID = DATA_W'(5 << (FRAC_W - 3));
    localparam logic [DATA_W-1:0] OFS_HI  = DATA_W'(27 << (FRAC_W - 5));
    localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    // Breakpoints belong to the upper segment, hence strict less-than.
    function automatic logic [DATA_W-1:0] pwl(input logic [DATA_W-1:0] a);
        if (a < ONE) begin
            pwl = (a >> 2) + OFS_LO;
        end else if (a < BP_MID) begin
            pwl = (a >> 3) + OFS_MID;
        end else if (a < BP_HIGH) begin
            pwl = (a >> 5) + OFS_HI;
        end else begin
            pwl = ONE;
        end
    endfunction

    logic [1:0][DATA_W-1:0] x_lane;
    logic [1:0][DATA_W-1:0] y_lane;
    logic [2:0]             valid_q;

    assign x_lane = {x1_in, x0_in};

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [DATA_W-1:0] abs_d;
        logic [DATA_W-1:0] abs_q;
        logic              sign1_q;
        logic [DATA_W-1:0] p_q;
        logic              sign2_q;
        logic [DATA_W-1:0] y_q;

        // The most negative input has no positive twin; clamp to the largest magnitude.
        always_comb begin
            abs_d = x_lane[l];
            if (x_lane[l][DATA_W-1]) begin
                abs_d = (x_lane[l] == NEG_MIN) ? POS_MAX : ('0 - x_lane[l]);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                abs_q   <= '0;
                sign1_q <= 1'b0;
                p_q     <= '0;
                sign2_q <= 1'b0;
                y_q     <= '0;
            end else begin
                abs_q   <= abs_d;
                sign1_q <= x_lane[l][DATA_W-1];
                p_q     <= pwl(abs_q);
                sign2_q <= sign1_q;
                y_q     <= sign2_q ? (ONE - p_q) : p_q;
            end
        end

        assign y_lane[l] = y_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[1:0], valid_in};
        end
    end

    assign y0_out    = y_lane[0];
    assign y1_out    = y_lane[1];
    assign valid_out = valid_q[2];

endmodule

// File: tb/tb_sigmoid_pwl7_dual.sv
// Directed bench for sigmoid_pwl7_dual: reset, single pairs, breakpoints, saturation,
// a 50-pair sweep against the real sigmoid, and a mid-stream reset.
module tb_sigmoid_pwl7_dual;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] x0_in = '0;
    logic [15:0] x1_in = '0;
    logic        valid_in = 1'b0;
    logic [15:0] y0_out;
    logic [15:0] y1_out;
    logic        valid_out;

    int total = 0;
    int bad = 0;

    sigmoid_pwl7_dual #(
        .DATA_W(16),
        .FRAC_W(11)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x0_in    (x0_in),
        .x1_in    (x1_in),
        .valid_in (valid_in),
        .y0_out   (y0_out),
        .y1_out   (y1_out),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Stream capture, enabled only while a sweep is running.
    logic        mon_en = 1'b0;
    logic [15:0] cap_q[$];
    int          cyc = 0;
    int          first_cyc = -1;
    int          last_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && valid_out) begin
            cap_q.push_back(y0_out);
            cap_q.push_back(y1_out);
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
    end

    // One pair for one cycle; valid_out must pulse exactly on the third edge after capture.
    task automatic run_pair(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] ea, input logic [15:0] eb);
        @(posedge clk);
        #1;
        x0_in    = a;
        x1_in    = b;
        valid_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            x0_in    = 16'h1234;
            x1_in    = 16'hC321;
            @(negedge clk);
            check_eq({tag, "_valid"}, 32'(valid_out), 32'(k == 3));
            if (k == 3) begin
                check_eq({tag, "_y0"}, 32'(y0_out), 32'(ea));
                check_eq({tag, "_y1"}, 32'(y1_out), 32'(eb));
            end
        end
    endtask

    function automatic logic [15:0] sweep_pt(input int i);
        return 16'(-20480 + (40960 * i) / 99);
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] ea;
        logic [15:0] eb;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{16'h0000, 16'h0400, 16'h0400, 16'h0500};
        vecs[1] = '{16'h0800, 16'hF800, 16'h0600, 16'h0200};
        vecs[2] = '{16'h1800, 16'hE800, 16'h0780, 16'h0080};
        vecs[3] = '{16'h5000, 16'hB000, 16'h0800, 16'h0000};
        vecs[4] = '{16'h7FFF, 16'h8000, 16'h0800, 16'h0000};

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_y0", 32'(y0_out), 32'h0);
        check_eq("rst_y1", 32'(y1_out), 32'h0);
        check_eq("rst_valid", 32'(valid_out), 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("idle_valid", 32'(valid_out), 32'h0);
        end

        for (int v = 0; v < 5; v++) begin
            run_pair($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].ea, vecs[v].eb);
        end

        // Sweep -10..+10, back-to-back.
        mon_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            x0_in    = sweep_pt(2 * i);
            x1_in    = sweep_pt(2 * i + 1);
            valid_in = 1'b1;
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        check_eq("sweep_count", 32'(cap_q.size()), 32'd100);
        check_eq("sweep_span", 32'(last_cyc - first_cyc), 32'd49);
        if (cap_q.size() == 100) begin
            for (int i = 0; i < 100; i++) begin
                real xr;
                real sig;
                real err;
                xr  = real'($signed(sweep_pt(i))) / 2048.0;
                sig = 1.0 / (1.0 + $exp(-xr));
                err = real'(cap_q[i]) / 2048.0 - sig;
                if (err < 0.0) err = -err;
                check_eq($sformatf("sweep_err%0d", i), 32'(err <= 0.02), 32'd1);
                check_eq($sformatf("sweep_range%0d", i), 32'(cap_q[i] <= 16'h0800), 32'd1);
                if (i > 0) begin
                    check_eq($sformatf("sweep_mono%0d", i), 32'(cap_q[i] >= cap_q[i-1]), 32'd1);
                end
            end
        end

        // Mid-stream reset: asynchronous clear, no stale valid after release.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            x0_in    = 16'h0800;
            x1_in    = 16'hF800;
            valid_in = 1'b1;
        end
        @(negedge clk);
        check_eq("pre_rst_valid", 32'(valid_out), 32'h1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_y0", 32'(y0_out), 32'h0);
        check_eq("mid_rst_y1", 32'(y1_out), 32'h0);
        check_eq("mid_rst_valid", 32'(valid_out), 32'h0);
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("post_rst_valid", 32'(valid_out), 32'h0);
        end
        run_pair("recover", 16'h0400, 16'h0000, 16'h0500, 16'h0400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
